multicycle_ctrl: RTL and testbench

//  Control unit for the multicycle ARM datapath (PC/IR/Data/A/WriteData/ALUOut registers, shared ALU).

---
 rtl/multicycle_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_cond_unit.sv | 66 ++++++
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// ============================================================================
// Module : multicycle_pkg
// Brief  : Shared encodings for the multicycle ARM control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCA_A      = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_cond_unit.sv
// ============================================================================
// Module : cond_unit
// Brief  : ARM condition evaluation, NZCV flag register and registered CondEx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    output logic       cond_ex_o,
    output logic       cond_ex_q_o
);
    import multicycle_pkg::*;

    logic [3:0] flags_q;
    logic       cond_ex_q;
    logic       n, z, c, v, ge;

    assign {n, z, c, v} = flags_q;
    assign ge           = (n == v);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~(c & ~z);
            COND_GE: cond_ex_o = ge;
            COND_LT: cond_ex_o = ~ge;
            COND_GT: cond_ex_o = ~z & ge;
            COND_LE: cond_ex_o = ~(~z & ge);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

    // Flags are gated by the instruction's own condition, evaluated on the old flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            cond_ex_q <= cond_ex_o;
            if (flag_w_i[1] & cond_ex_o)
                flags_q[3:2] <= alu_flags_i[3:2];
            if (flag_w_i[0] & cond_ex_o)
                flags_q[1:0] <= alu_flags_i[1:0];
        end
    end

    assign cond_ex_q_o = cond_ex_q;

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Decoder, Moore sequencer and enable gating for the multicycle ARM datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);
    import multicycle_pkg::*;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cmd;
    logic       i_bit, s_bit, l_bit;
    logic       dp_legal, no_write, reg_w, pcs, is_exec;
    logic [1:0] dp_alu, flag_w;
    logic       cond_ex, cond_ex_q;
    logic       w_unused;

    state_e state_q, state_d, state_v;
    logic   pcw, rgw, mmw, irw;

    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign rd       = Instr[15:12];
    assign cmd      = funct[4:1];
    assign i_bit    = funct[5];
    assign s_bit    = funct[0];
    assign l_bit    = funct[0];
    assign w_unused = &{1'b0, Instr[19:16], Instr[11:0]};

    always_comb begin
        dp_legal = 1'b1;
        no_write = 1'b0;
        dp_alu   = ALU_ADD;
        case (cmd)
            CMD_ADD: dp_alu = ALU_ADD;
            CMD_SUB: dp_alu = ALU_SUB;
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_CMP: begin
                dp_alu   = ALU_SUB;
                no_write = 1'b1;
            end
            default: dp_legal = 1'b0;
        endcase
    end

    assign reg_w     = ((op == OP_DP) & dp_legal & ~no_write) | ((op == OP_MEM) & l_bit);
    assign flag_w[1] = (op == OP_DP) & s_bit;
    // Carry/overflow only mean something for the arithmetic commands.
    assign flag_w[0] = flag_w[1] & dp_legal & ~dp_alu[1];
    assign pcs       = ((rd == 4'd15) & reg_w) | (op == OP_BR);

    assign RegSrc = {(op == OP_MEM) & ~l_bit, (op == OP_BR)};
    assign ImmSrc = op;

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (Instr[31:28]),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w & {2{is_exec}}),
        .cond_ex_o   (cond_ex),
        .cond_ex_q_o (cond_ex_q)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    // While reset is low the outputs show FETCH selects with every enable forced off.
    assign state_v = reset ? state_q : S_FETCH;

    always_comb begin
        state_d    = S_FETCH;
        pcw        = 1'b0;
        rgw        = 1'b0;
        mmw        = 1'b0;
        irw        = 1'b0;
        is_exec    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (state_v)
            S_FETCH: begin
                irw       = 1'b1;
                pcw       = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_DP:   state_d = !dp_legal ? S_UNKNOWN :
                                       (i_bit ? S_EXECUTEI : S_EXECUTER);
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = l_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rgw       = reg_w & cond_ex_q;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mmw    = cond_ex_q;
            end
            S_EXECUTER: begin
                is_exec    = 1'b1;
                ALUControl = dp_alu;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                is_exec    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                rgw = reg_w & cond_ex_q;
                pcw = pcs & cond_ex_q;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pcw       = cond_ex_q;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign PCWrite  = pcw & reset;
    assign RegWrite = rgw & reset;
    assign MemWrite = mmw & reset;
    assign IRWrite  = irw & reset;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Scoreboard bench: directed instructions with hand-computed per-cycle outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] act;

    // Non-execute cycles see flags that would clear Z if they were wrongly loaded.
    localparam logic [3:0] DF = 4'b1011;

    assign act = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    function automatic logic [16:0] v(input logic pcw, input logic rw, input logic mw,
                                      input logic irw, input logic adr, input logic [1:0] rsrc,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] res, input logic [1:0] imm,
                                      input logic [1:0] alu);
        return {pcw, rw, mw, irw, adr, rsrc, sa, sb, res, imm, alu};
    endfunction

    task automatic cyc(input logic rst, input logic [31:0] ins, input logic [3:0] fl,
                       input logic [16:0] e, input string nm);
        exp_t t;
        @(posedge clk);
        #1;
        reset    = rst;
        Instr    = ins;
        ALUFlags = fl;
        t.exp    = e;
        t.name   = nm;
        sb_q.push_back(t);
    endtask

    task automatic fd(input logic [31:0] ins, input logic [1:0] rsrc, input logic [1:0] imm,
                      input string nm);
        cyc(1'b1, ins, DF, v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rsrc, 2'b01, 2'b10, 2'b10, imm, 2'b00),
            {nm, "_fetch"});
        cyc(1'b1, ins, DF, v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rsrc, 2'b01, 2'b10, 2'b10, imm, 2'b00),
            {nm, "_decode"});
    endtask

    always @(negedge clk) begin
        exp_t t;
        if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            n_checks++;
            if (act !== t.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", t.name, act, t.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low for three cycles
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 32'h0, DF, v(0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00), "reset");

        // ADD R1,R2,R3
        fd(32'hE0821003, 2'b00, 2'b00, "add");
        cyc(1, 32'hE0821003, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "add_execr");
        cyc(1, 32'hE0821003, DF, v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "add_aluwb");

        // LDR
        fd(32'hE5921004, 2'b00, 2'b01, "ldr");
        cyc(1, 32'hE5921004, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00), "ldr_memadr");
        cyc(1, 32'hE5921004, DF, v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), "ldr_memrd");
        cyc(1, 32'hE5921004, DF, v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00), "ldr_memwb");

        // STR
        fd(32'hE5821004, 2'b10, 2'b01, "str");
        cyc(1, 32'hE5821004, DF, v(0,0,0,0,0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00), "str_memadr");
        cyc(1, 32'hE5821004, DF, v(0,0,1,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), "str_memwr");

        // SUBS R0,R0,#1 producing Z=1
        fd(32'hE2500001, 2'b00, 2'b00, "subs");
        cyc(1, 32'hE2500001, 4'b0100, v(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01), "subs_execi");
        cyc(1, 32'hE2500001, DF, v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "subs_aluwb");

        // BEQ taken, BNE not taken, ADDNE suppressed
        fd(32'h0A000002, 2'b01, 2'b10, "beq");
        cyc(1, 32'h0A000002, DF, v(1,0,0,0,0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "beq_branch");
        fd(32'h1A000002, 2'b01, 2'b10, "bne");
        cyc(1, 32'h1A000002, DF, v(0,0,0,0,0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "bne_branch");
        fd(32'h10821003, 2'b00, 2'b00, "addne");
        cyc(1, 32'h10821003, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "addne_execr");
        cyc(1, 32'h10821003, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "addne_aluwb");

        // AND register, ORR immediate
        fd(32'hE0021003, 2'b00, 2'b00, "and");
        cyc(1, 32'hE0021003, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10), "and_execr");
        cyc(1, 32'hE0021003, DF, v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "and_aluwb");
        fd(32'hE3811001, 2'b00, 2'b00, "orr");
        cyc(1, 32'hE3811001, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11), "orr_execi");
        cyc(1, 32'hE3811001, DF, v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "orr_aluwb");

        // CMP: SUB, no register write, sets Z=1 again
        fd(32'hE1500001, 2'b00, 2'b00, "cmp");
        cyc(1, 32'hE1500001, 4'b0110, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01), "cmp_execr");
        cyc(1, 32'hE1500001, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "cmp_aluwb");

        // ADD to R15 writes PC in ALUWB
        fd(32'hE082F003, 2'b00, 2'b00, "addpc");
        cyc(1, 32'hE082F003, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "addpc_execr");
        cyc(1, 32'hE082F003, DF, v(1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "addpc_aluwb");

        // Op=11 and illegal DP command both go through UNKNOWN
        fd(32'hEC000000, 2'b00, 2'b11, "op11");
        cyc(1, 32'hEC000000, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00), "op11_unknown");
        fd(32'hE0200000, 2'b00, 2'b00, "eor");
        cyc(1, 32'hE0200000, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), "eor_unknown");

        // LDR abandoned by reset during MEMRD
        fd(32'hE5921004, 2'b00, 2'b01, "ldrr");
        cyc(1, 32'hE5921004, DF, v(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00), "ldrr_memadr");
        cyc(0, 32'hE5921004, DF, v(0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00), "ldrr_reset");

        // Flags cleared by reset: BEQ not taken, BNE taken
        fd(32'h0A000002, 2'b01, 2'b10, "beq2");
        cyc(1, 32'h0A000002, DF, v(0,0,0,0,0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "beq2_branch");
        fd(32'h1A000002, 2'b01, 2'b10, "bne2");
        cyc(1, 32'h1A000002, DF, v(1,0,0,0,0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "bne2_branch");

        for (int k = 0; k < 10 && sb_q.size() != 0; k++)
            @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
